// File: rtl/stopwatch_arbiter.sv
// Round-robin arbiter that lends one stopwatch interval counter to NUM_REQ requesters.
// Optional: define STOPWATCH_ARB_TIMEOUT_EN to force-terminate intervals at MAX and block the owner.
module stopwatch_arbiter #(
    parameter int  DATA_WIDTH = 16,
    parameter int  MAX        = 99,
    parameter int  NUM_REQ    = 4,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  busy,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_count,
    output logic [ID_W-1:0]       res_id,
    output logic                  res_wrap,
    output logic [0:0]            state_dbg
);
    // Result handshake: a result transfers on every edge where res_valid and res_ready are
    // both high; res_count/res_id/res_wrap hold stable while res_valid is high.

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [DATA_WIDTH-1:0] MAX_V = DATA_WIDTH'(MAX);

    logic [0:0]            state_q, state_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic                  wrap_q, wrap_d;
    logic [ID_W-1:0]       last_q, last_d;
    logic                  res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0] res_count_q, res_count_d;
    logic [ID_W-1:0]       res_id_q, res_id_d;
    logic                  res_wrap_q, res_wrap_d;

    logic [NUM_REQ-1:0]    eligible;
    logic                  win_found;
    logic [ID_W-1:0]       win_idx;
    logic                  owner_req;

`ifdef STOPWATCH_ARB_TIMEOUT_EN
    logic [NUM_REQ-1:0]    blocked_q, blocked_d;
    logic                  timeout_hit;

    assign eligible = req & ~blocked_q;
`else
    assign eligible = req;
`endif

    // last_q doubles as the owner index while in RUN.
    assign owner_req = req[last_q];

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int idx;
            idx = (int'(last_q) + i) % NUM_REQ;
            if (!win_found && eligible[idx]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        count_d     = count_q;
        wrap_d      = wrap_q;
        last_d      = last_q;
        res_valid_d = res_valid_q;
        res_count_d = res_count_q;
        res_id_d    = res_id_q;
        res_wrap_d  = res_wrap_q;
`ifdef STOPWATCH_ARB_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif

        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (win_found && (!res_valid_q || res_ready)) begin
                    state_d = RUN;
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    count_d = '0;
                    wrap_d  = 1'b0;
                    last_d  = win_idx;
                end
            end
            RUN: begin
                if (!owner_req) begin
                    res_count_d = count_q;
                    res_id_d    = last_q;
                    res_wrap_d  = wrap_q;
                    res_valid_d = 1'b1;
                    gnt_d       = '0;
                    state_d     = IDLE;
                end
`ifdef STOPWATCH_ARB_TIMEOUT_EN
                else if (count_q == MAX_V) begin
                    res_count_d = MAX_V;
                    res_id_d    = last_q;
                    res_wrap_d  = 1'b1;
                    res_valid_d = 1'b1;
                    gnt_d       = '0;
                    state_d     = IDLE;
                    timeout_hit = 1'b1;
                end
`endif
                else if (count_q == MAX_V) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + DATA_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

`ifdef STOPWATCH_ARB_TIMEOUT_EN
    // A block lifts once its requester has been seen low at an edge.
    always_comb begin
        blocked_d = blocked_q & req;
        if (timeout_hit) begin
            blocked_d[last_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blocked_q <= '0;
        end else begin
            blocked_q <= blocked_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            count_q     <= '0;
            wrap_q      <= 1'b0;
            last_q      <= ID_W'(NUM_REQ - 1);
            res_valid_q <= 1'b0;
            res_count_q <= '0;
            res_id_q    <= '0;
            res_wrap_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            count_q     <= count_d;
            wrap_q      <= wrap_d;
            last_q      <= last_d;
            res_valid_q <= res_valid_d;
            res_count_q <= res_count_d;
            res_id_q    <= res_id_d;
            res_wrap_q  <= res_wrap_d;
        end
    end

    assign gnt       = gnt_q;
    assign count     = count_q;
    assign busy      = (state_q == RUN);
    assign res_valid = res_valid_q;
    assign res_count = res_count_q;
    assign res_id    = res_id_q;
    assign res_wrap  = res_wrap_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_stopwatch_arbiter.sv
// Self-checking bench for stopwatch_arbiter: directed scenarios plus a randomized run
// against an interval-level reference model (held-edge counts, queue of expected results).
module tb_stopwatch_arbiter;
  localparam int DW    = 16;
  localparam int MAXV  = 99;
  localparam int NR    = 4;
  localparam int IDW   = 2;
  localparam int RES_W = IDW + 1 + DW;

  logic           clk;
  logic           reset;
  logic [NR-1:0]  req;
  logic [NR-1:0]  gnt;
  logic [DW-1:0]  count;
  logic           busy;
  logic           res_valid;
  logic           res_ready;
  logic [DW-1:0]  res_count;
  logic [IDW-1:0] res_id;
  logic           res_wrap;
  logic [0:0]     state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [RES_W-1:0] exp_q[$];

  // reference model state: interval owner and number of edges it has held req since grant
  bit            m_run;
  bit            m_rv;
  int            m_owner;
  int            m_last;
  int            m_held;
  int            m_target;
  logic [NR-1:0] m_blk;

  stopwatch_arbiter #(.DATA_WIDTH(DW), .MAX(MAXV), .NUM_REQ(NR)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .count(count), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count),
    .res_id(res_id), .res_wrap(res_wrap), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req = '0;
    res_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = 4'b0101;
    res_ready = 1'b1;
    repeat (2) tick();
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    n_checks++; if (count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if ({res_valid, res_count, res_id, res_wrap} !== '0) begin
      n_fail++; $display("FAIL reset_result: got v=%b c=%0d id=%0d w=%b expected all 0", res_valid, res_count, res_id, res_wrap);
    end
    reset = 1'b1;
    tick();
    n_checks++; if (gnt !== 4'b0001 || busy !== 1'b1) begin n_fail++; $display("FAIL first_grant: got gnt=%b busy=%b expected 0001 1", gnt, busy); end
    repeat (5) tick();
    n_checks++; if (count !== 16'd5) begin n_fail++; $display("FAIL hold5_count: got %0d expected 5", count); end
    req = 4'b0100;
    tick();
    n_checks++; if (res_valid !== 1'b1 || res_count !== 16'd5 || res_id !== 2'd0 || res_wrap !== 1'b0 || gnt !== 4'b0000) begin
      n_fail++; $display("FAIL hold5_result: got v=%b c=%0d id=%0d w=%b gnt=%b expected 1 5 0 0 0000", res_valid, res_count, res_id, res_wrap, gnt);
    end
    tick();
    n_checks++; if (gnt !== 4'b0100 || res_valid !== 1'b0) begin n_fail++; $display("FAIL accept_grant2: got gnt=%b v=%b expected 0100 0", gnt, res_valid); end
    req = '0;
    repeat (2) tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    res_ready = 1'b1;
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % NR;
      n_checks++; if (gnt !== (4'b0001 << e)) begin n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", k, gnt, 4'b0001 << e); end
      repeat (3) tick();
      req = 4'b1111 & ~(4'b0001 << e);
      tick();
      n_checks++; if (res_valid !== 1'b1 || res_count !== 16'd3 || res_id !== IDW'(e)) begin
        n_fail++; $display("FAIL rr_result%0d: got v=%b c=%0d id=%0d expected 1 3 %0d", k, res_valid, res_count, res_id, e);
      end
      req = 4'b1111;
      if (k < 4) tick();
    end
    req = '0;
    repeat (2) tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 4'b0001;
    tick();
    repeat (2) tick();
    req = 4'b0100;
    tick();
    n_checks++; if (res_valid !== 1'b1 || res_count !== 16'd2 || res_id !== 2'd0) begin
      n_fail++; $display("FAIL bp_capture: got v=%b c=%0d id=%0d expected 1 2 0", res_valid, res_count, res_id);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if (gnt !== 4'b0000 || res_valid !== 1'b1 || res_count !== 16'd2 || res_id !== 2'd0 || res_wrap !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d: got gnt=%b v=%b c=%0d id=%0d w=%b expected 0000 1 2 0 0", i, gnt, res_valid, res_count, res_id, res_wrap);
      end
    end
    res_ready = 1'b1;
    tick();
    n_checks++; if (gnt !== 4'b0100 || res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got gnt=%b v=%b expected 0100 0", gnt, res_valid); end
    req = '0;
    tick();
    n_checks++; if (res_valid !== 1'b1 || res_count !== 16'd0 || res_id !== 2'd2) begin
      n_fail++; $display("FAIL bp_second: got v=%b c=%0d id=%0d expected 1 0 2", res_valid, res_count, res_id);
    end
    tick();
  endtask

`ifndef STOPWATCH_ARB_TIMEOUT_EN
  task automatic test_wrap();
    do_reset();
    res_ready = 1'b1;
    req = 4'b0001;
    tick();
    repeat (105) tick();
    n_checks++; if (count !== 16'd5 || gnt !== 4'b0001) begin n_fail++; $display("FAIL wrap_count: got c=%0d gnt=%b expected 5 0001", count, gnt); end
    req = '0;
    tick();
    n_checks++; if (res_valid !== 1'b1 || res_count !== 16'd5 || res_wrap !== 1'b1) begin
      n_fail++; $display("FAIL wrap_result: got v=%b c=%0d w=%b expected 1 5 1", res_valid, res_count, res_wrap);
    end
    tick();
  endtask
`else
  task automatic test_timeout();
    do_reset();
    res_ready = 1'b1;
    req = 4'b0001;
    tick();
    repeat (99) tick();
    n_checks++; if (count !== 16'd99 || gnt !== 4'b0001) begin n_fail++; $display("FAIL to_count: got c=%0d gnt=%b expected 99 0001", count, gnt); end
    tick();
    n_checks++; if (gnt !== 4'b0000 || res_valid !== 1'b1 || res_count !== 16'd99 || res_wrap !== 1'b1) begin
      n_fail++; $display("FAIL to_result: got gnt=%b v=%b c=%0d w=%b expected 0000 1 99 1", gnt, res_valid, res_count, res_wrap);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL to_blocked%0d: got %b expected 0000", i, gnt); end
    end
    req = '0;
    tick();
    req = 4'b0001;
    tick();
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL to_regrant: got %b expected 0001", gnt); end
    req = '0;
    repeat (2) tick();
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    res_ready = 1'b1;
    req = 4'b0001;
    tick();
    repeat (40) tick();
    n_checks++; if (count !== 16'd40) begin n_fail++; $display("FAIL ar_count: got %0d expected 40", count); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'b0000 || count !== 16'd0 || res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ar_immediate: got gnt=%b c=%0d v=%b busy=%b expected 0000 0 0 0", gnt, count, res_valid, busy);
    end
    tick();
    reset = 1'b1;
    req = '0;
  endtask

  // one clock edge of the interval-level reference model, given the inputs sampled at that edge
  task automatic model_step(input logic [NR-1:0] r, input logic rdy);
    bit            rv_old;
    logic [NR-1:0] elig;
    rv_old = m_rv;
    elig = r & ~m_blk;
    m_blk = m_blk & r;
    if (m_rv && rdy) m_rv = 0;
    if (m_run) begin
      if (!r[m_owner]) begin
        exp_q.push_back({IDW'(m_owner), 1'(m_held > MAXV), DW'(m_held % (MAXV + 1))});
        m_rv = 1;
        m_run = 0;
      end
`ifdef STOPWATCH_ARB_TIMEOUT_EN
      else if (m_held == MAXV) begin
        exp_q.push_back({IDW'(m_owner), 1'b1, DW'(MAXV)});
        m_rv = 1;
        m_run = 0;
        m_blk[m_owner] = 1'b1;
      end
`endif
      else begin
        m_held++;
      end
    end else if (elig != '0 && (!rv_old || rdy)) begin
      for (int k = 1; k <= NR; k++) begin
        int idx;
        idx = (m_last + k) % NR;
        if (!m_run && elig[idx]) begin
          m_run = 1;
          m_owner = idx;
          m_last = idx;
          m_held = 0;
          m_target = ($urandom_range(0, 7) == 0) ? int'($urandom_range(95, 130)) : int'($urandom_range(0, 8));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [RES_W-1:0] obs;
    logic [RES_W-1:0] expv;
    do_reset();
    m_run = 0; m_rv = 0; m_owner = 0; m_last = NR - 1; m_held = 0; m_target = 0; m_blk = '0;
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic [NR-1:0] eg;
      eg = m_run ? (4'b0001 << m_owner) : 4'b0000;
      n_checks++; if (gnt !== eg || busy !== 1'(m_run)) begin n_fail++; $display("FAIL rnd_gnt c%0d: got gnt=%b busy=%b expected %b %b", c, gnt, busy, eg, m_run); end
      n_checks++; if (count !== DW'(m_held % (MAXV + 1))) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d expected %0d", c, count, m_held % (MAXV + 1)); end
      n_checks++; if (res_valid !== 1'(m_rv)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, res_valid, m_rv); end
      req = 4'($urandom_range(0, 15));
      if (m_run) req[m_owner] = (m_held < m_target);
      res_ready = ($urandom_range(0, 3) != 0);
      if (res_valid && res_ready) begin
        obs = {res_id, res_wrap, res_count};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_result c%0d: got %h expected none", c, obs);
        end else begin
          expv = exp_q.pop_front();
          if (obs !== expv) begin n_fail++; $display("FAIL rnd_result c%0d: got id=%0d w=%b c=%0d expected id=%0d w=%b c=%0d", c, res_id, res_wrap, res_count, expv[RES_W-1 -: IDW], expv[DW], expv[DW-1:0]); end
        end
      end
      model_step(req, res_ready);
      tick();
    end
    req = '0;
  endtask

  initial begin
    reset = 1'b0;
    req = '0;
    res_ready = 1'b0;
    #2;
    test_reset();
    test_round_robin();
    test_backpressure();
`ifndef STOPWATCH_ARB_TIMEOUT_EN
    test_wrap();
`else
    test_timeout();
`endif
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stopwatch_arbiter.md
# stopwatch_arbiter

Round-robin arbiter and sequencer that shares one stopwatch-style interval counter between `NUM_REQ` requesters. It grants the counter to one requester at a time and runs the count for as long as that requester holds its request. When the interval ends, it returns the captured count, the owner ID and a wrap flag through a valid/ready result port. It sits between the timing clients and the display/readout logic, replacing per-client stopwatch instances.

## Interface
- `DATA_WIDTH`, 16, width of count and result; `MAX` must be < 2^DATA_WIDTH
- `MAX`, 99, terminal count; increment from `MAX` goes to 0
- `NUM_REQ`, 4, number of requesters (≥2); `ID_W = $clog2(NUM_REQ)`
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-low reset
- `req`  input  NUM_REQ  level request per requester; the owner's deassertion ends its interval
- `gnt`  output  NUM_REQ  one-hot grant; all zero when idle
- `count`  output  DATA_WIDTH  live counter value
- `busy`  output  1  high while in RUN
- `res_valid`  output  1  result available
- `res_ready`  input  1  result consumer accepts
- `res_count`  output  DATA_WIDTH  captured interval count
- `res_id`  output  ID_W  index of the requester that owned the interval
- `res_wrap`  output  1  counter passed `MAX` (or timed out) during the interval

## Operation
- FSM states are IDLE and RUN.
- Reset values:
  - state IDLE
  - `gnt`=0, `count`=0, `busy`=0
  - `res_valid`=0, `res_count`=0, `res_id`=0, `res_wrap`=0
  - round-robin pointer `last`=NUM_REQ-1, so req[0] has first priority
- Reset is asynchronous. Assertion mid-RUN aborts the interval immediately, and any pending result is lost.
- IDLE → RUN when any eligible `req` bit is high and (`!res_valid` || `res_ready`).
  - The winner is the first set bit searching `last+1, last+2, …` modulo NUM_REQ.
  - At that edge: `gnt` gets the winner's one-hot bit, `count`←0, internal wrap flag←0, `last`←winner.
- RUN, with `req[owner]` sampled high:
  - `count`←(`count`==MAX) ? 0 : `count`+1.
  - The wrap flag is set when the wrap occurs and stays set (sticky).
- RUN, with `req[owner]` sampled low:
  - Capture at that edge: `res_count`←`count` (not incremented), `res_id`←owner, `res_wrap`←wrap flag.
  - `res_valid`←1, `gnt`←0, state←IDLE.
- Requests from non-owners during RUN are ignored and are not latched. A requester that withdraws `req` before being granted is simply not served.
- Result port:
  - `res_valid && res_ready` at an edge clears `res_valid`, unless the same edge captures a new result.
  - `res_count`, `res_id` and `res_wrap` hold stable while `res_valid` is high.
- A grant is never issued while a result is pending and unaccepted. Accept and grant may occur on the same edge. A new capture therefore never overwrites an unaccepted result.

## Timing
- Grant latency: 1 edge from `req` sampled high in IDLE to `gnt` high.
- Result latency: 1 edge from `req[owner]` sampled low to `res_valid` high.
- An owner that holds `req` for N edges after the grant edge yields `res_count`=N mod (MAX+1), provided N ≤ MAX or the wrap path is taken.
- Minimum spacing between consecutive grants is 2 edges (capture edge, then grant/accept edge).
- `count` holds its last value in IDLE until the next grant clears it.

## Configuration
- `STOPWATCH_ARB_TIMEOUT_EN` defined:
  - In RUN, with `count`==MAX and `req[owner]` high, the interval is force-terminated instead of wrapping: `res_count`←MAX, `res_wrap`←1, `gnt`←0, state IDLE.
  - The timed-out requester is marked blocked and is ineligible for grant until it deasserts `req` for at least one edge. Reset clears all blocked flags.
- Not defined: the counter wraps MAX→0 indefinitely, `res_wrap` reports the wrap, and no blocked flags exist.

## Test plan
- Reset with `req`=4'b0101 held: after release, `gnt`=0001 at first edge; owner holds 5 edges then drops → `res_count`=5, `res_id`=0, `res_wrap`=0.
- Round-robin: `req`=4'b1111 constant, each owner drops for one cycle after 3 counts, `res_ready`=1 → grant order 0,1,2,3,0; each `res_count`=3.
- Backpressure: `res_ready`=0, result pending, `req[2]` high → no `gnt` for 10 cycles, results stable; raise `res_ready` → accept and `gnt`=0100 on the same edge.
- Wrap (macro off), MAX=99: owner holds 105 edges → `res_count`=5, `res_wrap`=1.
- Timeout (macro on), MAX=99: owner holds `req` indefinitely → after 99 increments `res_count`=99, `res_wrap`=1, `gnt`=0; owner not regranted until it drops `req` one cycle.
- Asynchronous reset asserted mid-RUN with `count`=40 → `gnt`, `count`, `res_valid` go to 0 immediately, without a clock edge.
